mat_vec_mac_stream: RTL and testbench
=====================================

// Module: mat_vec_mac_stream
// PURPOSE
//   Streaming, parametrised matrix-vector multiply-accumulate: out = M * X, with optional
//   accumulation across consecutive beats so matrices wider than Ndata are tiled by column.
//   valid/ready on both sides with full backpressure; signed or unsigned operands.
//   Sits between the operand fetch/buffer stage and the result writeback in the matmul datapath.
// PARAMETERS
//   Mdata    4  rows of M / elements of out
//   Ndata    4  columns of M / elements of X (>=1)
//   Nbits    4  operand element width
//   SIGNED   0  1: operands and result two's complement; 0: unsigned
//   ACC_EXT  4  extra accumulator guard bits for tiling
//   ACCW     2*Nbits+$clog2(Ndata)+ACC_EXT (derived localparam, not overridable); result element width
// PORTS
//   clk        in   1                  clock, rising edge
//   reset      in   1                  asynchronous, active-low reset
//   in_valid   in   1                  beat present on M/X/in_first/in_last
//   in_ready   out  1                  beat accepted when in_valid & in_ready
//   M          in   Mdata*Ndata*Nbits  row r at [r*Ndata*Nbits +: Ndata*Nbits]; elem c of row at [c*Nbits +: Nbits]
//   X          in   Ndata*Nbits        elem c at [c*Nbits +: Nbits]
//   in_first   in   1                  beat starts a new accumulation (acc <= partial)
//   in_last    in   1                  beat ends accumulation; produces one output
//   out_valid  out  1                  out holds a result
//   out_ready  in   1                  result consumed when out_valid & out_ready
//   out        out  Mdata*ACCW         row r at [r*ACCW +: ACCW]
// BEHAVIOUR
//   - Reset (reset==0, async): out_valid=0, out=0, all stage valids=0, accumulators=0; in_ready=0 while
//     reset is asserted, and reset to its normal value in the first cycle after release.
//   - 3 stages: S1 register Mdata*Ndata products (sign/zero-extended to ACCW); S2 register per-row sum
//     (adder tree); S3 accumulate + output register. Latency accept->out_valid = 3 cycles, no stall.
//   - Global advance en = ~(out_valid & ~out_ready); in_ready = en. On en=0 every stage holds;
//     no beat lost or duplicated. Throughput 1 beat/cycle when out_ready stays 1.
//   - in_first/in_last travel with their beat. At S3: in_first ? acc<=partial : acc<=acc+partial.
//     out_valid asserted and out<=acc-new only on in_last beats; non-last beats never raise out_valid.
//   - first&last in same beat: single-beat result. Non-first beat with no open accumulation: adds to
//     stale acc (caller error, no flag). Accumulation wraps modulo 2^ACCW.
//   - Arithmetic: SIGNED=1 sign-extends operands, out is two's complement; SIGNED=0 zero-extends.
//   - out_valid drops on handshake unless a new in_last beat arrives in the same cycle (back-to-back).
//   - Reset mid-operation discards all in-flight beats and any open accumulation.
// STRUCTURE
//   - mat_vec_pkg: ACCW width function, element slice helpers, SIGNED extension function.
//   - Sub-module row_dot (one row: Ndata products + registered adder tree), instanced Mdata times
//     under a generate loop; stage control, flags and accumulators stay in this module.
// TESTING (Mdata=Ndata=Nbits=4, ACCW=14 unless noted)
//   1 rows M0={5,6,7,1} M1={4,3,2,1} M2={4,5,0,0} M3={1,3,5,2} (elem3..0), X={1,2,1,1}, first=last=1
//     -> out rows 25,13,14,14, out_valid 3 cycles after accept.
//   2 same operands, two beats: first=1/last=0 then first=0/last=1 -> single output 50,26,28,28;
//     no out_valid after first beat.
//   3 SIGNED=1, all M elems 4'hF, all X elems 4'h7 -> every row 14'h3FE4 (-28).
//   4 4 back-to-back single beats, out_ready=1 -> 4 outputs on 4 consecutive cycles; then out_ready=0
//     5 cycles -> out stable, in_ready=0, no loss; release -> remaining results in order.
//   5 reset pulled low with 2 beats in flight -> out_valid=0 and out=0 immediately; after release
//     no stale result appears; next single beat yields correct result.

Source files
------------

// File: rtl/mat_vec_pkg.sv
// Shared helpers for the streaming matrix-vector MAC: accumulator width,
// operand slice offsets and the sign/zero extension fill bit.
package mat_vec_pkg;

  // Result width: full product, growth of an Ndata-term sum, plus guard bits
  // so that column tiles can be accumulated across beats.
  function automatic int acc_width(input int nbits, input int ndata, input int acc_ext);
    return 2 * nbits + $clog2(ndata) + acc_ext;
  endfunction

  // Bit offset of element idx inside a packed vector of nbits-wide elements.
  function automatic int elem_lsb(input int idx, input int nbits);
    return idx * nbits;
  endfunction

  // Bit offset of row r inside the packed matrix operand.
  function automatic int row_lsb(input int row, input int ndata, input int nbits);
    return row * ndata * nbits;
  endfunction

  // Fill bit used when widening an operand: copies the MSB in signed mode,
  // zero in unsigned mode.
  function automatic logic ext_fill(input logic msb, input bit sgn);
    return sgn & msb;
  endfunction

endpackage

// File: rtl/mat_vec_mac_stream_row_dot.sv
// One matrix row dot product: Ndata widened products registered (stage 1),
// then summed and registered (stage 2). Both stages advance only on en.
module row_dot
  import mat_vec_pkg::*;
#(
  parameter int Ndata  = 4,
  parameter int Nbits  = 4,
  parameter int SIGNED = 0,
  parameter int ACCW   = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [Ndata*Nbits-1:0] row,
  input  logic [Ndata*Nbits-1:0] x,
  output logic [ACCW-1:0]        sum
);

  logic [ACCW-1:0] prod_d [Ndata];
  logic [ACCW-1:0] prod_q [Ndata];
  logic [ACCW-1:0] sum_d;

  // Widen both operands to ACCW before multiplying; the low ACCW bits of the
  // product are then correct for both two's complement and unsigned data.
  for (genvar c = 0; c < Ndata; c++) begin : g_elem
    logic [Nbits-1:0] a;
    logic [Nbits-1:0] b;
    logic [ACCW-1:0]  a_ext;
    logic [ACCW-1:0]  b_ext;
    assign a     = row[elem_lsb(c, Nbits) +: Nbits];
    assign b     = x[elem_lsb(c, Nbits) +: Nbits];
    assign a_ext = {{(ACCW-Nbits){ext_fill(a[Nbits-1], SIGNED != 0)}}, a};
    assign b_ext = {{(ACCW-Nbits){ext_fill(b[Nbits-1], SIGNED != 0)}}, b};
    assign prod_d[c] = a_ext * b_ext;
  end

  // Stage 1: product registers, held while the pipeline is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < Ndata; c++) prod_q[c] <= '0;
    end else if (en) begin
      for (int c = 0; c < Ndata; c++) prod_q[c] <= prod_d[c];
    end
  end

  // Sum of the registered products, wrapping modulo 2^ACCW.
  always_comb begin
    sum_d = '0;
    for (int c = 0; c < Ndata; c++) sum_d = sum_d + prod_q[c];
  end

  // Stage 2: per-row partial sum register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sum <= '0;
    else if (en) sum <= sum_d;
  end

endmodule

// File: rtl/mat_vec_mac_stream.sv
// Streaming matrix-vector multiply-accumulate, out = M * X, with optional
// accumulation across beats so wide matrices can be tiled by column.
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high; the source holds valid and its payload stable until that edge, and
// ready never depends on valid. Here one global enable advances all three
// stages together, so in_ready is simply "the output register can move".
module mat_vec_mac_stream
  import mat_vec_pkg::*;
#(
  parameter int Mdata   = 4,
  parameter int Ndata   = 4,
  parameter int Nbits   = 4,
  parameter int SIGNED  = 0,
  parameter int ACC_EXT = 4
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [Mdata*Ndata*Nbits-1:0]                        M,
  input  logic [Ndata*Nbits-1:0]                              X,
  input  logic                                                in_first,
  input  logic                                                in_last,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [Mdata*acc_width(Nbits, Ndata, ACC_EXT)-1:0]   out
);

  localparam int ACCW = acc_width(Nbits, Ndata, ACC_EXT);

  logic            en;
  logic            live;
  logic            accept;
  logic            v1, f1, l1;
  logic            v2, f2, l2;
  logic [ACCW-1:0] partial [Mdata];
  logic [ACCW-1:0] acc_q   [Mdata];
  logic [ACCW-1:0] acc_new [Mdata];

  // Everything moves unless a finished result is waiting on the consumer.
  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = en & live;
  assign accept   = in_valid & in_ready;

  // Keeps in_ready low while reset is held; rises on the first clock after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Beat valid and first/last flags travel alongside the data stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0; f1 <= 1'b0; l1 <= 1'b0;
      v2 <= 1'b0; f2 <= 1'b0; l2 <= 1'b0;
    end else if (en) begin
      v1 <= accept;
      f1 <= in_first;
      l1 <= in_last;
      v2 <= v1;
      f2 <= f1;
      l2 <= l1;
    end
  end

  // One dot-product pipeline per output row.
  for (genvar r = 0; r < Mdata; r++) begin : g_row
    row_dot #(
      .Ndata  (Ndata),
      .Nbits  (Nbits),
      .SIGNED (SIGNED),
      .ACCW   (ACCW)
    ) u_row (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .row   (M[row_lsb(r, Ndata, Nbits) +: Ndata*Nbits]),
      .x     (X),
      .sum   (partial[r])
    );
  end

  // A first beat restarts the accumulation; later beats add to it.
  always_comb begin
    for (int r = 0; r < Mdata; r++) acc_new[r] = '0;
    for (int r = 0; r < Mdata; r++) acc_new[r] = f2 ? partial[r] : acc_q[r] + partial[r];
  end

  // Stage 3: accumulators and the output register. Only last beats publish;
  // when en is high any displayed result is being consumed, so out_valid
  // falls unless a new last beat replaces it in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < Mdata; r++) acc_q[r] <= '0;
      out_valid <= 1'b0;
      out       <= '0;
    end else if (en) begin
      if (v2) begin
        for (int r = 0; r < Mdata; r++) acc_q[r] <= acc_new[r];
      end
      if (v2 && l2) begin
        out_valid <= 1'b1;
        for (int r = 0; r < Mdata; r++) out[r*ACCW +: ACCW] <= acc_new[r];
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mat_vec_mac_stream.sv
// Bench for mat_vec_mac_stream: an unsigned and a signed instance share all
// inputs; a scoreboard of expected results is checked as outputs are consumed.
module tb_mat_vec_mac_stream;

  localparam int MD = 4;
  localparam int ND = 4;
  localparam int NB = 4;
  localparam int AW = 14;
  localparam int OW = MD * AW;

  typedef struct {
    string           name;
    logic [63:0]     m;
    logic [15:0]     x;
    logic [OW-1:0]   exp_u;
    logic [OW-1:0]   exp_s;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_first;
  logic          in_last;
  logic [63:0]   m_in;
  logic [15:0]   x_in;
  logic          out_ready;
  logic          in_ready, in_ready_s;
  logic          out_valid, out_valid_s;
  logic [OW-1:0] out, out_s;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  int            last_out_cyc = 0;
  int            n_out = 0;
  int            out_cyc_q[$];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] exp_s_q[$];
  int            acc_u[MD];
  int            acc_s[MD];
  vec_t          tbl[6];
  logic [63:0]   rm[6];
  logic [15:0]   rx[6];
  logic [OW-1:0] held;
  bit            rand_done;

  mat_vec_mac_stream #(.Mdata(MD), .Ndata(ND), .Nbits(NB), .SIGNED(0), .ACC_EXT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .M(m_in), .X(x_in),
    .in_first(in_first), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  mat_vec_mac_stream #(.Mdata(MD), .Ndata(ND), .Nbits(NB), .SIGNED(1), .ACC_EXT(4)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s), .M(m_in), .X(x_in),
    .in_first(in_first), .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready), .out(out_s)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack_rows(input int r0, input int r1, input int r2, input int r3);
    logic [OW-1:0] v;
    v = '0;
    v[0*AW +: AW] = AW'(r0);
    v[1*AW +: AW] = AW'(r1);
    v[2*AW +: AW] = AW'(r2);
    v[3*AW +: AW] = AW'(r3);
    return v;
  endfunction

  // ---------------- reference model ----------------
  function automatic int elem(input logic [63:0] v, input int idx, input bit sgn);
    logic [63:0] sh;
    int e;
    sh = v >> (idx * NB);
    e = int'(sh[3:0]);
    if (sgn && e >= 8) e = e - 16;
    return e;
  endfunction

  // Plain integer dot products per row, accumulated and wrapped to 14 bits.
  task automatic model_accept(input logic [63:0] mm, input logic [15:0] xx, input bit f, input bit l);
    for (int r = 0; r < MD; r++) begin
      int pu, ps;
      pu = 0;
      ps = 0;
      for (int c = 0; c < ND; c++) begin
        pu += elem(mm, r*ND + c, 1'b0) * elem({48'd0, xx}, c, 1'b0);
        ps += elem(mm, r*ND + c, 1'b1) * elem({48'd0, xx}, c, 1'b1);
      end
      acc_u[r] = (f ? pu : acc_u[r] + pu) & 32'h3FFF;
      acc_s[r] = (f ? ps : acc_s[r] + ps) & 32'h3FFF;
    end
    if (l) begin
      exp_q.push_back(pack_rows(acc_u[0], acc_u[1], acc_u[2], acc_u[3]));
      exp_s_q.push_back(pack_rows(acc_s[0], acc_s[1], acc_s[2], acc_s[3]));
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (reset && out_valid && out_ready) begin
      n_out++;
      last_out_cyc = cyc;
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got out %h required no result", out);
      end else begin
        check("out_unsigned", out, exp_q.pop_front());
        check("out_signed", out_s, exp_s_q.pop_front());
        check("out_valid_signed", OW'(out_valid_s), OW'(1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [63:0] mm, input logic [15:0] xx, input logic f, input logic l);
    int budget;
    budget = 500;
    @(negedge clk);
    in_valid = 1'b1;
    m_in     = mm;
    x_in     = xx;
    in_first = f;
    in_last  = l;
    #1;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0 required 1");
    end
    @(posedge clk);
    acc_cyc = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      #2;
      budget--;
    end
    check_int(name, exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    m_in      = '0;
    x_in      = '0;
    out_ready = 1'b1;
    for (int r = 0; r < MD; r++) begin
      acc_u[r] = 0;
      acc_s[r] = 0;
    end

    tbl[0] = '{"t1_basic", 64'h1352_4500_4321_5671, 16'h1211,
               pack_rows(25, 13, 14, 14), pack_rows(25, 13, 14, 14)};
    tbl[1] = '{"t3_neg_times_7", 64'hFFFF_FFFF_FFFF_FFFF, 16'h7777,
               pack_rows(420, 420, 420, 420), pack_rows(-28, -28, -28, -28)};
    tbl[2] = '{"zero", 64'h0, 16'h0, pack_rows(0, 0, 0, 0), pack_rows(0, 0, 0, 0)};
    tbl[3] = '{"min_times_min", 64'h8888_8888_8888_8888, 16'h8888,
               pack_rows(256, 256, 256, 256), pack_rows(256, 256, 256, 256)};
    tbl[4] = '{"all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF,
               pack_rows(900, 900, 900, 900), pack_rows(4, 4, 4, 4)};
    tbl[5] = '{"mixed_sign", 64'h0000_0000_0000_00F1, 16'h0032,
               pack_rows(47, 0, 0, 0), pack_rows(-1, 0, 0, 0)};

    // Reset state
    #2 reset = 1'b0;
    #3;
    check("rst_out_valid", OW'(out_valid), OW'(0));
    check("rst_out", out, '0);
    check("rst_in_ready", OW'(in_ready), OW'(0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready_after_release", OW'(in_ready), OW'(1));

    // Table-driven single beats with latency
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].exp_u);
      exp_s_q.push_back(tbl[i].exp_s);
      send(tbl[i].m, tbl[i].x, 1'b1, 1'b1);
      idle();
      wait_drain({tbl[i].name, "_drain"});
      check_int({tbl[i].name, "_latency"}, last_out_cyc - acc_cyc, 3);
    end

    // Two-beat accumulation produces exactly one result
    begin
      int n0;
      n0 = n_out;
      exp_q.push_back(pack_rows(50, 26, 28, 28));
      exp_s_q.push_back(pack_rows(50, 26, 28, 28));
      send(tbl[0].m, tbl[0].x, 1'b1, 1'b0);
      send(tbl[0].m, tbl[0].x, 1'b0, 1'b1);
      idle();
      wait_drain("t2_drain");
      repeat (3) @(negedge clk);
      #2;
      check_int("t2_output_count", n_out - n0, 1);
      check_int("t2_latency", last_out_cyc - acc_cyc, 3);
    end

    // Four back-to-back single beats -> four consecutive outputs
    out_cyc_q.delete();
    for (int i = 0; i < 4; i++) begin
      rm[i] = {$urandom, $urandom};
      rx[i] = 16'($urandom);
      model_accept(rm[i], rx[i], 1'b1, 1'b1);
      send(rm[i], rx[i], 1'b1, 1'b1);
    end
    idle();
    wait_drain("t4_drain");
    check_int("t4_out_count", out_cyc_q.size(), 4);
    for (int i = 1; i < 4; i++) begin
      if (i < out_cyc_q.size()) check_int("t4_consecutive", out_cyc_q[i] - out_cyc_q[i-1], 1);
    end

    // Stall with the pipeline full: output frozen, no beat lost
    for (int i = 0; i < 6; i++) begin
      rm[i] = {$urandom, $urandom};
      rx[i] = 16'($urandom);
      model_accept(rm[i], rx[i], 1'b1, 1'b1);
    end
    fork
      begin
        for (int i = 0; i < 6; i++) send(rm[i], rx[i], 1'b1, 1'b1);
        idle();
      end
      begin
        int b;
        b = 100;
        do begin
          @(negedge clk);
          #1;
          b--;
        end while (!out_valid && b > 0);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        held = out;
        check("t4_stall_valid", OW'(out_valid), OW'(1));
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          #1;
          check("t4_stall_out_stable", out, held);
          check("t4_stall_in_ready", OW'(in_ready), OW'(0));
          check("t4_stall_in_ready_s", OW'(in_ready_s), OW'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drain("t4_stall_drain");

    // Randomized tiles with random backpressure and input gaps
    rand_done = 1'b0;
    fork
      begin
        for (int g = 0; g < 25; g++) begin
          int nb;
          nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++) begin
            logic [63:0] mm;
            logic [15:0] xx;
            mm = {$urandom, $urandom};
            xx = 16'($urandom);
            model_accept(mm, xx, b == 0, b == nb - 1);
            send(mm, xx, b == 0, b == nb - 1);
            if ($urandom_range(0, 3) == 0) idle();
          end
        end
        idle();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    wait_drain("random_drain");

    // Reset with two beats in flight
    begin
      int n0;
      send(tbl[0].m, tbl[0].x, 1'b1, 1'b1);
      send(tbl[1].m, tbl[1].x, 1'b1, 1'b1);
      #3;
      reset    = 1'b0;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      #1;
      check("t5_out_valid", OW'(out_valid), OW'(0));
      check("t5_out", out, '0);
      check("t5_out_signed", out_s, '0);
      check("t5_in_ready", OW'(in_ready), OW'(0));
      for (int r = 0; r < MD; r++) begin
        acc_u[r] = 0;
        acc_s[r] = 0;
      end
      n0 = n_out;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      #2;
      check_int("t5_no_stale_result", n_out - n0, 0);
      check("t5_in_ready_after", OW'(in_ready), OW'(1));
      rm[0] = {$urandom, $urandom};
      rx[0] = 16'($urandom);
      model_accept(rm[0], rx[0], 1'b1, 1'b1);
      send(rm[0], rx[0], 1'b1, 1'b1);
      idle();
      wait_drain("t5_drain");
      check_int("t5_latency", last_out_cyc - acc_cyc, 3);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
